ct_lsu_dcache_tag_arb_ctrl: RTL

Arbiter and sequencer for the L1 dcache load-side tag array: shares the single-port 2-way tag SRAM between load-pipe reads, snoop reads and refill-buffer writes, and runs a full-index zeroing sweep after reset and on a cp0 invalidate-all request. It sits directly in front of the tag array macro and drives its gated-clock enable, chip select, write enables, index and write data. It also returns registered read-valid and source tags alongside the array output.

---
 rtl/ct_lsu_dcache_tag_arb_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ct_lsu_dcache_tag_arb_ctrl.sv
// ct_lsu_dcache_tag_arb_ctrl
// Arbiter/sequencer in front of the single-port 2-way dcache load-side tag
// array. Shares the array between refill writes, snoop reads and load reads,
// and runs a full-index zeroing sweep after reset and on invalidate-all.
//
// Ports:
//   forever_cpuclk, cpurst_b        clock, synchronous active-low reset
//   inv_all_req / inv_all_done      invalidate-all request / completion pulse
//   ctrl_busy                       sweep in progress
//   ld_*, snq_*                     tag read requests and grants
//   rb_wr_*                         refill tag write request and grant
//   tag_gateclk_en .. tag_din       array controls (sel/gwen/wen active-low)
//   tag_dout                        array Q
//   rd_vld, rd_src, rd_tag_dout     read return, one cycle after a read grant
module ct_lsu_dcache_tag_arb_ctrl #(
    parameter int unsigned IDX_W = 9,
    parameter int unsigned WAY_W = 27
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst_b,
    input  logic                 inv_all_req,
    output logic                 inv_all_done,
    output logic                 ctrl_busy,
    input  logic                 ld_req,
    input  logic [IDX_W-1:0]     ld_idx,
    output logic                 ld_grnt,
    input  logic                 snq_req,
    input  logic [IDX_W-1:0]     snq_idx,
    output logic                 snq_grnt,
    input  logic                 rb_wr_req,
    input  logic [IDX_W-1:0]     rb_wr_idx,
    input  logic                 rb_wr_way,
    input  logic [WAY_W-1:0]     rb_wr_tag,
    output logic                 rb_wr_grnt,
    output logic                 tag_gateclk_en,
    output logic                 tag_sel_b,
    output logic                 tag_gwen_b,
    output logic [1:0]           tag_wen_b,
    output logic [IDX_W-1:0]     tag_idx,
    output logic [2*WAY_W-1:0]   tag_din,
    input  logic [2*WAY_W-1:0]   tag_dout,
    output logic                 rd_vld,
    output logic [1:0]           rd_src,
    output logic [2*WAY_W-1:0]   rd_tag_dout
);

    localparam int unsigned DIN_W     = 2 * WAY_W;
    localparam int unsigned STARV_W   = 2;
    localparam logic [IDX_W-1:0]   IDX_LAST  = '1;
    localparam logic [STARV_W-1:0] STARV_MAX = '1;

    typedef enum logic [1:0] {
        SWEEP_RST = 2'd0,
        RUN       = 2'd1,
        SWEEP_INV = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [STARV_W-1:0]  starv_q, starv_d;
    logic                rd_vld_q, rd_vld_d;
    logic [1:0]          rd_src_q, rd_src_d;
    logic                done_q, done_d;

    logic                ld_g, snq_g, wr_g;
    logic                sel_b, gwen_b;
    logic [1:0]          wen_b;
    logic [IDX_W-1:0]    idx;
    logic [DIN_W-1:0]    din;

    // State and return-path registers
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q  <= SWEEP_RST;
            cnt_q    <= '0;
            starv_q  <= '0;
            rd_vld_q <= 1'b0;
            rd_src_q <= 2'b00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starv_q  <= starv_d;
            rd_vld_q <= rd_vld_d;
            rd_src_q <= rd_src_d;
            done_q   <= done_d;
        end
    end

    // Next state, arbitration and array controls
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starv_d  = starv_q;
        done_d   = 1'b0;
        ld_g     = 1'b0;
        snq_g    = 1'b0;
        wr_g     = 1'b0;
        sel_b    = 1'b1;
        gwen_b   = 1'b1;
        wen_b    = 2'b11;
        idx      = '0;
        din      = '0;

        // While reset is asserted the array stays deselected
        if (cpurst_b) begin
            unique case (state_q)
                SWEEP_RST, SWEEP_INV: begin
                    sel_b  = 1'b0;
                    gwen_b = 1'b0;
                    wen_b  = 2'b00;
                    idx    = cnt_q;
                    cnt_d  = IDX_W'(cnt_q + 1'b1);
                    if (cnt_q == IDX_LAST) begin
                        state_d = RUN;
                        done_d  = (state_q == SWEEP_INV);
                    end
                end
                RUN: begin
                    if (inv_all_req) begin
                        // Sweep starts next cycle; no access this cycle
                        state_d = SWEEP_INV;
                    end else if (ld_req && (starv_q == STARV_MAX)) begin
                        ld_g = 1'b1;
                    end else if (rb_wr_req) begin
                        wr_g = 1'b1;
                    end else if (snq_req) begin
                        snq_g = 1'b1;
                    end else if (ld_req) begin
                        ld_g = 1'b1;
                    end

                    if (wr_g) begin
                        sel_b  = 1'b0;
                        gwen_b = 1'b0;
                        wen_b  = rb_wr_way ? 2'b01 : 2'b10;
                        idx    = rb_wr_idx;
                        din    = {rb_wr_tag, rb_wr_tag};
                    end else if (snq_g) begin
                        sel_b = 1'b0;
                        idx   = snq_idx;
                    end else if (ld_g) begin
                        sel_b = 1'b0;
                        idx   = ld_idx;
                    end

                    // Load starvation: saturating count of denied load cycles
                    if (ld_req && !ld_g) begin
                        if (starv_q != STARV_MAX) begin
                            starv_d = STARV_W'(starv_q + 1'b1);
                        end
                    end else begin
                        starv_d = '0;
                    end
                end
                default: begin
                    state_d = SWEEP_RST;
                    cnt_d   = '0;
                end
            endcase
        end

        rd_vld_d = ld_g | snq_g;
        rd_src_d = {snq_g, ld_g};
    end

    assign ld_grnt        = ld_g;
    assign snq_grnt       = snq_g;
    assign rb_wr_grnt     = wr_g;
    assign tag_sel_b      = sel_b;
    assign tag_gwen_b     = gwen_b;
    assign tag_wen_b      = wen_b;
    assign tag_idx        = idx;
    assign tag_din        = din;
    assign tag_gateclk_en = ~sel_b;

    assign ctrl_busy      = (state_q != RUN);
    assign inv_all_done   = done_q;
    assign rd_vld         = rd_vld_q;
    assign rd_src         = rd_src_q;
    assign rd_tag_dout    = tag_dout;

endmodule
